// File: rtl/ps_pwm_pkg.sv
// Shared constants and helpers for the phase-shifted PWM generator.
// Holds the default parameter set and the per-cell carrier phase offset.
package ps_pwm_pkg;

   localparam int DefNumCells   = 2;
   localparam int DefCntWidth   = 7;
   localparam int DefCarrierTop = 100;
   localparam int DefDtWidth    = 5;
   localparam int DefTrigOnPeak = 0;

   // Offset of cell k along the 2*top carrier period, spreading cells evenly.
   function automatic int phase_offset(int k, int num_cells, int top);
      return (k * 2 * top) / num_cells;
   endfunction

endpackage

// File: rtl/ps_pwm_gen_if.sv
// Duty/dead-time configuration bus of ps_pwm_gen.
// The controller drives the master side and the generator samples the slave side.
interface ps_pwm_gen_if #(
   parameter int NumCells = 2,
   parameter int CntWidth = 7,
   parameter int DtWidth  = 5
);
   logic [NumCells*CntWidth-1:0] duty_i;
   logic                         duty_valid_i;
   logic [DtWidth-1:0]           dt_i;

   modport master (output duty_i, duty_valid_i, dt_i);
   modport slave  (input  duty_i, duty_valid_i, dt_i);
endinterface

// File: rtl/ps_pwm_gen_leg.sv
// One inverter leg: registered carrier compare plus complementary gate pair
// with dead time; a gate turns on only after its level has held dt+1 cycles.
module pwm_leg
   import ps_pwm_pkg::*;
#(
   parameter int CntWidth   = DefCntWidth,
   parameter int CarrierTop = DefCarrierTop,
   parameter int DtWidth    = DefDtWidth
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                run_i,
   input  logic [CntWidth-1:0] duty_i,
   input  logic [CntWidth-1:0] tri_i,
   input  logic [DtWidth-1:0]  dt_i,
   output logic                hi_o,
   output logic                lo_o
);

   logic                raw_q, raw_d;
   logic [DtWidth:0]    run_q, run_d;
   logic                hi_q, hi_d;
   logic                lo_q, lo_d;
   logic [CntWidth-1:0] duty_sat;

   // run_q counts consecutive cycles raw_q has held its level, saturating.
   always_comb begin
      duty_sat = (duty_i > CntWidth'(CarrierTop)) ? CntWidth'(CarrierTop + 1) : duty_i;
      raw_d    = run_i & (duty_sat > tri_i);
      if (!run_i)                run_d = '0;
      else if (raw_d != raw_q)   run_d = (DtWidth+1)'(1);
      else if (run_q != '1)      run_d = run_q + 1'b1;
      else                       run_d = run_q;
      hi_d = run_i &  raw_q & (run_q > {1'b0, dt_i});
      lo_d = run_i & ~raw_q & (run_q > {1'b0, dt_i});
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         raw_q <= 1'b0;
         run_q <= '0;
         hi_q  <= 1'b0;
         lo_q  <= 1'b0;
      end else begin
         raw_q <= raw_d;
         run_q <= run_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

   // Gates drop in the same cycle the generator stops running.
   assign hi_o = hi_q & run_i;
   assign lo_o = lo_q & run_i;

endmodule

// File: rtl/ps_pwm_gen.sv
// Phase-shifted triangle-carrier PWM generator: NumCells legs sharing one
// master position, shadowed duty/dead-time, ADC trigger and latched fault trip.
module ps_pwm_gen
   import ps_pwm_pkg::*;
#(
   parameter int NumCells   = DefNumCells,
   parameter int CntWidth   = DefCntWidth,
   parameter int CarrierTop = DefCarrierTop,
   parameter int DtWidth    = DefDtWidth,
   parameter int TrigOnPeak = DefTrigOnPeak
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   ps_pwm_gen_if.slave         cfg,
   input  logic                fault_i,
   input  logic                fault_clr_i,
   output logic [NumCells-1:0] pwm_hi_o,
   output logic [NumCells-1:0] pwm_lo_o,
   output logic                adc_trigger_o,
   output logic                fault_o
);

   localparam int PosWidth = CntWidth + 1;
   localparam int Period   = 2 * CarrierTop;
   localparam int DutyBits = NumCells * CntWidth;

   logic [PosWidth-1:0] pos_q, pos_d;
   logic [DutyBits-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
   logic [DtWidth-1:0]  dt_sh_q, dt_sh_d, dt_act_q, dt_act_d;
   logic                fault_q, fault_d;
   logic                running;
   logic                load;

   always_comb begin
      running   = en_i & ~fault_q & ~fault_i & ~rst_i;
      load      = ~running | (pos_q == '0);
      duty_sh_d = cfg.duty_valid_i ? cfg.duty_i : duty_sh_q;
      dt_sh_d   = cfg.duty_valid_i ? cfg.dt_i   : dt_sh_q;
      // The active set seen by the legs this cycle already includes a pos==0 load.
      duty_act_d = load ? duty_sh_q : duty_act_q;
      dt_act_d   = load ? dt_sh_q   : dt_act_q;
      // NOTE: every branch assigns pos_d, so no latch is inferred.
      if (!running)                              pos_d = '0;
      else if (pos_q == PosWidth'(Period - 1))   pos_d = '0;
      else                                       pos_d = pos_q + 1'b1;
      fault_d = fault_i | (fault_q & ~fault_clr_i);
   end

   // NOTE: shadow and active duty are ordinary flops, cleared so legs start idle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pos_q      <= '0;
         duty_sh_q  <= '0;
         duty_act_q <= '0;
         dt_sh_q    <= '0;
         dt_act_q   <= '0;
         fault_q    <= 1'b0;
      end else begin
         pos_q      <= pos_d;
         duty_sh_q  <= duty_sh_d;
         duty_act_q <= duty_act_d;
         dt_sh_q    <= dt_sh_d;
         dt_act_q   <= dt_act_d;
         fault_q    <= fault_d;
      end
   end

   for (genvar k = 0; k < NumCells; k++) begin : g_cell
      localparam int Off = phase_offset(k, NumCells, CarrierTop);

      logic [PosWidth:0]   pos_sum;
      logic [PosWidth-1:0] cell_pos;
      logic [CntWidth-1:0] carrier;

      always_comb begin
         pos_sum  = {1'b0, pos_q} + (PosWidth+1)'(Off);
         cell_pos = (pos_sum >= (PosWidth+1)'(Period))
                  ? PosWidth'(pos_sum - (PosWidth+1)'(Period)) : PosWidth'(pos_sum);
         carrier  = (cell_pos <= PosWidth'(CarrierTop))
                  ? CntWidth'(cell_pos) : CntWidth'(PosWidth'(Period) - cell_pos);
      end

      pwm_leg #(
         .CntWidth   (CntWidth),
         .CarrierTop (CarrierTop),
         .DtWidth    (DtWidth)
      ) u_leg (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .run_i  (running),
         .duty_i (duty_act_d[k*CntWidth +: CntWidth]),
         .tri_i  (carrier),
         .dt_i   (dt_act_d),
         .hi_o   (pwm_hi_o[k]),
         .lo_o   (pwm_lo_o[k])
      );
   end

   assign adc_trigger_o = running & ((pos_q == '0) |
                          ((TrigOnPeak != 0) & (pos_q == PosWidth'(CarrierTop))));
   assign fault_o       = fault_q;

endmodule

// File: doc/ps_pwm_gen.md
PS_PWM_GEN -- requirements
Module: ps_pwm_gen

Interface
REQ-001 Parameter NumCells, default 2: number of phase-shifted legs; carrier phase step 360/NumCells degrees.
REQ-002 Parameter CntWidth, default 7: carrier and duty width; SHALL hold CarrierTop+1.
REQ-003 Parameter CarrierTop, default 100: triangle peak; carrier period = 2*CarrierTop cycles.
REQ-004 Parameter DtWidth, default 5: dead-time counter width.
REQ-005 Parameter TrigOnPeak, default 0: 1 = ADC trigger at both valley and peak of cell 0.
REQ-006 clk_i  in  1  single system clock; all logic on rising edge.
REQ-007 rst_i  in  1  synchronous, active-high reset.
REQ-008 en_i  in  1  run enable; low = outputs off, carrier parked.
REQ-009 duty_i  in  NumCells*CntWidth  packed duty words, cell k at bits [k*CntWidth +: CntWidth].
REQ-010 duty_valid_i  in  1  one-cycle strobe capturing duty_i and dt_i into shadow registers.
REQ-011 dt_i  in  DtWidth  dead time in clk_i cycles.
REQ-012 fault_i  in  1  external trip, level.
REQ-013 fault_clr_i  in  1  clears latched fault.
REQ-014 pwm_hi_o  out  NumCells  high-side gate commands, active-high.
REQ-015 pwm_lo_o  out  NumCells  low-side gate commands, active-high.
REQ-016 adc_trigger_o  out  1  one-cycle ADC sample strobe.
REQ-017 fault_o  out  1  latched fault status.

Function
REQ-018 Master position pos counts 0..2*CarrierTop-1, wraps to 0; cell k position = (pos + floor(k*2*CarrierTop/NumCells)) mod 2*CarrierTop; carrier tri_k = p if p<=CarrierTop else 2*CarrierTop-p.
REQ-019 Active duty/dt SHALL load from shadow only at pos==0 (or every cycle while parked); mid-period shadow writes take effect at next pos==0.
REQ-020 Duty values >CarrierTop SHALL saturate to CarrierTop+1 (100% high side); duty 0 = 0% high side.
REQ-021 Registered compare raw_k = (duty_k > tri_k), one cycle after tri_k.
REQ-022 pwm_hi_o[k]: falls 1 cycle after raw_k falls; rises dt+1 cycles after raw_k rises, only if raw_k stayed high throughout; raw pulses shorter than dt+1 cycles suppressed.
REQ-023 pwm_lo_o[k]: same rule applied to ~raw_k.
REQ-024 pwm_hi_o[k] and pwm_lo_o[k] SHALL never be simultaneously high for any dt, duty or transition.
REQ-025 adc_trigger_o pulses one cycle when pos==0 while running; if TrigOnPeak=1 also when pos==CarrierTop.
REQ-026 fault_i high SHALL set fault_o on next edge; fault_o holds until fault_clr_i high with fault_i low; simultaneous fault_i and fault_clr_i keeps fault.
REQ-027 Running = en_i & ~fault_o & ~fault_i; when not running all pwm outputs 0 in the same cycle (combinational gating), pos held 0, dead-time counters cleared, adc_trigger_o 0.
REQ-028 Resume from not-running SHALL start at pos=0, both gates off, legs obeying REQ-022/023 from cleared state.

Reset
REQ-029 rst_i high: pos=0, shadow and active duty=0, dt=0, raw=0, fault_o=0, pwm_hi_o=0, pwm_lo_o=0, adc_trigger_o=0; reset mid-period aborts period immediately.

Structure
REQ-030 Shared package ps_pwm_pkg: default parameter constants and phase-offset function.
REQ-031 Sub-module pwm_leg: one registered compare input plus complementary dead-time pair; instantiated NumCells times.

Verification
REQ-032 rst_i high 3 cycles mid-run -> all outputs 0, fault_o 0 from next edge.
REQ-033 NumCells=2, duty 50/50, dt=2 -> per 200 cycles: hi high 97, lo high 99 cycles; cell 1 waveform = cell 0 delayed 100 cycles; adc_trigger_o every 200 cycles.
REQ-034 duty 30 running, write 80 at pos=50 -> current period unchanged, new duty from next pos==0.
REQ-035 duty 0 -> hi constant 0, lo constant 1; duty 127 -> saturates, hi constant 1, lo 0; never overlap.
REQ-036 duty 1, dt=2 -> raw high 1 cycle per period, hi stays 0.
REQ-037 fault_i pulse at pos=120 -> outputs 0 same cycle, fault_o 1 until fault_clr_i; then resume at pos=0 with first trigger.
